// File: rtl/avr_tx_arbiter_pkg.sv
// Shared definitions for the AVR transmit arbiter: FSM encoding, default sizes
// and the wrap-around index helper used by the round-robin picker.
package avr_tx_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT   = 4;
  localparam int MAX_BURST_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  function automatic int wrap_index(input int base, input int offs, input int n);
    return (base + offs) % n;
  endfunction

endpackage

// File: rtl/avr_tx_arbiter_rr_picker.sv
// Combinational round-robin select: first set request strictly after ptr_i,
// wrapping, so the pointer position itself has lowest priority.
module avr_tx_arbiter_rr_picker
  import avr_tx_arbiter_pkg::*;
#(
  parameter int N     = NUM_REQ_DEFAULT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    for (int k = 1; k <= N; k++) begin
      cand = wrap_index(int'(ptr_i), k, N);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/avr_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the AVR serial transmit path
// between NUM_REQ byte-stream requesters; all outputs registered.
module avr_tx_arbiter
  import avr_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT,
  parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 link_ready,
  input  logic                 tx_block,
  input  logic                 tx_busy,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data
);

  localparam int                 IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   PTR_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [BURST_W-1:0] LAST_CNT  = BURST_W'(MAX_BURST - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic                 release_q, release_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 new_q, new_d;
  logic [7:0]           txd_q, txd_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  logic                 own_req;
  logic                 own_last;
  logic [7:0]           own_data;

  avr_tx_arbiter_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // grant_q is one-hot or zero, so masking selects the owner's signals.
  assign own_req  = |(req & grant_q);
  assign own_last = |(req_last & grant_q);

  always_comb begin
    own_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        own_data = own_data | req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    release_d = release_q;
    ack_d     = '0;
    new_d     = 1'b0;
    txd_d     = txd_q;

    if (!link_ready) begin
      // Abort keeps the pointer so the same requester wins on link return.
      state_d   = ST_IDLE;
      grant_d   = '0;
      cnt_d     = '0;
      release_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_d   = ST_SEND;
            grant_d   = pick_onehot;
            owner_d   = pick_idx;
            cnt_d     = '0;
            release_d = 1'b0;
          end
        end
        ST_SEND: begin
          if (!own_req) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = owner_q;
            cnt_d   = '0;
          end else if (!tx_block && !tx_busy) begin
            state_d   = ST_GAP;
            new_d     = 1'b1;
            txd_d     = own_data;
            ack_d     = grant_q;
            cnt_d     = cnt_q + 1'b1;
            release_d = own_last || (cnt_q == LAST_CNT);
          end
        end
        ST_GAP: begin
          if (release_q) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = owner_q;
            cnt_d   = '0;
          end else begin
            state_d = ST_SEND;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= PTR_RESET;
      cnt_q     <= '0;
      release_q <= 1'b0;
      ack_q     <= '0;
      new_q     <= 1'b0;
      txd_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      release_q <= release_d;
      ack_q     <= ack_d;
      new_q     <= new_d;
      txd_q     <= txd_d;
    end
  end

  assign grant       = grant_q;
  assign req_ack     = ack_q;
  assign new_tx_data = new_q;
  assign tx_data     = txd_q;

endmodule

// File: tb/tb_avr_tx_arbiter.sv
// Bench for avr_tx_arbiter: vector table, directed corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_avr_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           link_ready;
  logic           tx_block;
  logic           tx_busy;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           new_tx_data;

  always #5 clk = ~clk;

  avr_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst         (rst),
    .link_ready  (link_ready),
    .tx_block    (tx_block),
    .tx_busy     (tx_busy),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ack     (req_ack),
    .grant       (grant),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transmitter stand-in: busy rises the cycle after a strobe, lasts busy_len cycles.
  bit txm_en;
  int busy_len;
  int busy_left;
  bit arm;

  task automatic tick();
    @(posedge clk);
    #1;
    if (txm_en) begin
      if (arm) begin
        busy_left = busy_len;
        arm = 1'b0;
      end
      tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (new_tx_data) arm = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; link_ready = 1'b0; tx_block = 1'b0; tx_busy = 1'b0;
    req = '0; req_last = '0; req_data = '0;
    arm = 1'b0; busy_left = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic       lr, blk, busy;
    logic [3:0] rq, lst, eg, ea;
    logic       en;
    logic [7:0] etx;
  } vec_t;
  vec_t tbl [15];

  // Reference model state: owner -1 means nobody holds the link.
  int         m_owner, m_ptr, m_sent;
  bit         m_gap, m_rel;
  logic [7:0] m_txd;

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_sent = 0; m_gap = 0; m_rel = 0; m_txd = 8'h00;
  endtask

  task automatic model_step(output logic [N-1:0] eg, output logic [N-1:0] ea, output logic en);
    en = 1'b0;
    ea = '0;
    if (!link_ready) begin
      m_owner = -1; m_gap = 0; m_sent = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req[c]) begin
          m_owner = c; m_sent = 0;
          break;
        end
      end
    end else if (m_gap) begin
      m_gap = 0;
      if (m_rel) begin m_ptr = m_owner; m_owner = -1; end
    end else if (!req[m_owner]) begin
      m_ptr = m_owner; m_owner = -1;
    end else if (!tx_block && !tx_busy) begin
      en = 1'b1;
      ea[m_owner] = 1'b1;
      m_txd = req_data[8*m_owner +: 8];
      m_sent++;
      m_rel = req_last[m_owner] || (m_sent == MB);
      m_gap = 1;
    end
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    txm_en = 1'b0;
    busy_len = 2;

    // ---------------- reset state ----------------
    do_reset();
    chk("reset_grant", grant, 0);
    chk("reset_ack", req_ack, 0);
    chk("reset_new", new_tx_data, 0);
    chk("reset_txdata", tx_data, 0);

    // ---------------- vector table ----------------
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 8'hA5};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'hA5};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'hA5};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'b0110, 4'b0110, 4'b0010, 4'b0000, 1'b0, 8'hA5};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'b0110, 4'b0110, 4'b0010, 4'b0000, 1'b0, 8'hA5};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'b0110, 4'b0110, 4'b0010, 4'b0010, 1'b1, 8'h22};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 8'h22};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0, 8'h22};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 8'h22};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b1100, 4'b0100, 4'b0000, 1'b0, 8'h22};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 4'b1100, 4'b1100, 4'b0100, 4'b0000, 1'b0, 8'h22};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b1100, 4'b0100, 4'b0100, 1'b1, 8'h33};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 8'h33};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b0, 8'h33};

    req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    for (int r = 0; r < 15; r++) begin
      link_ready = tbl[r].lr; tx_block = tbl[r].blk; tx_busy = tbl[r].busy;
      req = tbl[r].rq; req_last = tbl[r].lst;
      tick();
      chk($sformatf("tbl%0d_grant", r), grant, tbl[r].eg);
      chk($sformatf("tbl%0d_ack", r), req_ack, tbl[r].ea);
      chk($sformatf("tbl%0d_new", r), new_tx_data, tbl[r].en);
      chk($sformatf("tbl%0d_txdata", r), tx_data, tbl[r].etx);
    end

    // ---------------- round robin over 1111 ----------------
    begin
      int order[$];
      int acks[5];
      int bad;
      logic [N-1:0] prev;
      foreach (acks[k]) acks[k] = 0;
      bad = 0; prev = '0;
      txm_en = 1'b1; busy_len = 2;
      do_reset();
      link_ready = 1'b1; req = 4'b1111; req_last = 4'b1111;
      for (int c = 0; c < 100 && order.size() < 5; c++) begin
        tick();
        if (!$onehot0(grant)) bad++;
        if (grant != 0 && prev == 0) order.push_back(onehot_idx(grant));
        if (req_ack != 0) begin
          if (req_ack !== grant || order.size() == 0) bad++;
          else acks[order.size() - 1]++;
        end
        prev = grant;
      end
      chk("rr_grant_count", order.size(), 5);
      for (int k = 0; k < order.size() && k < 5; k++)
        chk($sformatf("rr_order%0d", k), order[k], k % N);
      for (int k = 0; k < 4; k++) chk($sformatf("rr_acks%0d", k), acks[k], 1);
      chk("rr_overlap", bad, 0);
    end

    // ---------------- MAX_BURST forced rotation ----------------
    begin
      int q[$];
      int ones, pos1;
      txm_en = 1'b1; busy_len = 2;
      do_reset();
      link_ready = 1'b1; req = 4'b0011; req_last = 4'b0010;
      req_data = {8'h00, 8'h00, 8'h5C, 8'h10};
      pos1 = -1;
      for (int c = 0; c < 500 && !(pos1 >= 0 && q.size() > pos1 + 1); c++) begin
        tick();
        if (req_ack != 0) begin
          q.push_back(onehot_idx(req_ack));
          if (req_ack[1]) begin
            pos1 = q.size() - 1;
            req[1] = 1'b0; req_last[1] = 1'b0;
          end
        end
      end
      ones = 0;
      foreach (q[k]) if (q[k] == 1) ones++;
      chk("burst_pos_of_req1", pos1, MB);
      chk("burst_req1_acks", ones, 1);
      chk("burst_resume_req0", (pos1 >= 0 && q.size() > pos1 + 1) ? q[pos1 + 1] : -1, 0);
    end

    // ---------------- tx_block hold ----------------
    begin
      int strobes, lost;
      txm_en = 1'b0;
      do_reset();
      link_ready = 1'b1; tx_block = 1'b1; req = 4'b0001; req_last = 4'b0001;
      req_data = {8'h00, 8'h00, 8'h00, 8'h7E};
      tick();
      chk("blk_grant", grant, 4'b0001);
      strobes = 0; lost = 0;
      for (int c = 0; c < 50; c++) begin
        tick();
        if (new_tx_data) strobes++;
        if (grant !== 4'b0001) lost++;
      end
      chk("blk_no_strobe", strobes, 0);
      chk("blk_grant_held", lost, 0);
      tx_block = 1'b0;
      tick();
      chk("blk_release_new", new_tx_data, 1);
      chk("blk_release_data", tx_data, 8'h7E);
      chk("blk_release_ack", req_ack, 4'b0001);
    end

    // ---------------- reset during GAP ----------------
    txm_en = 1'b0;
    do_reset();
    link_ready = 1'b1; req = 4'b0100; req_last = 4'b0100;
    req_data = {8'h00, 8'h9D, 8'h00, 8'h00};
    tick(); tick();
    chk("gaprst_pre_new", new_tx_data, 1);
    chk("gaprst_pre_grant", grant, 4'b0100);
    rst = 1'b1; req = 4'b1111; req_last = 4'b1111;
    tick();
    chk("gaprst_grant", grant, 0);
    chk("gaprst_ack", req_ack, 0);
    chk("gaprst_new", new_tx_data, 0);
    chk("gaprst_txdata", tx_data, 0);
    rst = 1'b0;
    tick();
    chk("gaprst_regrant", grant, 4'b0001);

    // ---------------- randomized vs reference model ----------------
    begin
      int         left [N];
      logic [7:0] dat [N];
      logic [N-1:0] eg, ea;
      logic en;
      txm_en = 1'b1;
      do_reset();
      model_reset();
      foreach (left[i]) begin left[i] = 0; dat[i] = 8'h00; end
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < N; i++) begin
          if (left[i] == 0 && $urandom_range(0, 3) == 0) begin
            left[i] = $urandom_range(1, 24);
            dat[i] = 8'($urandom);
          end
          req[i] = (left[i] > 0) && ($urandom_range(0, 59) != 0);
          req_last[i] = (left[i] == 1);
          req_data[8*i +: 8] = dat[i];
        end
        link_ready = ($urandom_range(0, 39) != 0);
        tx_block = ($urandom_range(0, 5) == 0);
        busy_len = $urandom_range(1, 4);
        model_step(eg, ea, en);
        tick();
        chk("rnd_grant", grant, eg);
        chk("rnd_ack", req_ack, ea);
        chk("rnd_new", new_tx_data, en);
        chk("rnd_txdata", tx_data, m_txd);
        for (int i = 0; i < N; i++) begin
          if (ea[i]) begin
            left[i]--;
            dat[i] = 8'($urandom);
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
